// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control FSM (fetch/decode/exec/mem/wb) for a 32-bit datapath
// Inputs : clk, reset (async, active-high), instr (IR contents), zero (ALU flag),
//          mem_ready (shared memory port completes this cycle)
// Outputs: mem_req/mem_we/iord (memory handshake), irwrite/pcwrite (IR/PC enables),
//          regwrite, memtoreg, alusrc, regdst, pcsrc, jump, jrsrc, jalsrc, alucontrol,
//          halted, and illegal when CTRL_TRAP_EN is defined (undefined encodings trap to HALT;
//          otherwise they retire as a NOP through WB).
module multicycle_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] instr,
  input  logic         zero,
  input  logic         mem_ready,
  output logic         mem_req,
  output logic         mem_we,
  output logic         iord,
  output logic         irwrite,
  output logic         pcwrite,
  output logic         regwrite,
  output logic         memtoreg,
  output logic         alusrc,
  output logic         regdst,
  output logic         pcsrc,
  output logic         jump,
  output logic         jrsrc,
  output logic         jalsrc,
  output logic [3:0]   alucontrol,
  output logic         halted
`ifdef CTRL_TRAP_EN
  ,
  output logic         illegal
`endif
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEMRD, S_MEMWR, S_WB, S_HALT} state_t;
  state_t r_state, w_next;
  logic [5:0] w_op;
  logic [4:0] w_funct;
  logic w_ralu, w_jr, w_lw, w_sw, w_beq, w_addi, w_j, w_jal, w_halt, w_legal, w_mem_alu;
  logic w_unused;
  assign w_op      = instr[31:26];
  assign w_funct   = instr[4:0];
  assign w_unused  = ^instr[25:5];
  assign w_ralu    = w_op == 6'b000000 && !w_funct[4];
  assign w_jr      = w_op == 6'b000000 && w_funct == 5'b10000;
  assign w_lw      = w_op == 6'b100011;
  assign w_sw      = w_op == 6'b101011;
  assign w_beq     = w_op == 6'b000100;
  assign w_addi    = w_op == 6'b001000;
  assign w_j       = w_op == 6'b000010;
  assign w_jal     = w_op == 6'b000011;
  assign w_halt    = w_op == 6'b111111;
  assign w_mem_alu = w_lw || w_sw || w_addi;
  assign w_legal   = w_ralu || w_jr || w_mem_alu || w_beq || w_j || w_jal || w_halt;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
`ifdef CTRL_TRAP_EN
  logic r_illegal;
  // Set on the same edge that enters HALT, so it rises together with halted.
  always_ff @(posedge clk or posedge reset)
    if (reset) r_illegal <= 1'b0;
    else if (r_state == S_DECODE && !w_legal) r_illegal <= 1'b1;
  assign illegal = r_illegal;
`endif
  // Outputs are forced low while reset is held so an in-flight request drops at once.
  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    alusrc     = 1'b0;
    regdst     = 1'b0;
    pcsrc      = 1'b0;
    jump       = 1'b0;
    jrsrc      = 1'b0;
    jalsrc     = 1'b0;
    alucontrol = 4'b0000;
    halted     = 1'b0;
    if (!reset) case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        irwrite = mem_ready;
        w_next  = mem_ready ? S_DECODE : S_FETCH;
      end
`ifdef CTRL_TRAP_EN
      S_DECODE: w_next = (w_halt || !w_legal) ? S_HALT : S_EXEC;
`else
      S_DECODE: w_next = w_halt ? S_HALT : w_legal ? S_EXEC : S_WB;
`endif
      S_EXEC: begin
        alusrc     = w_mem_alu;
        alucontrol = w_ralu ? instr[3:0] : w_beq ? 4'b0110 : w_mem_alu ? 4'b0010 : 4'b0000;
        pcsrc      = w_beq && zero;
        jump       = w_j || w_jal;
        jalsrc     = w_jal;
        regwrite   = w_jal;
        jrsrc      = w_jr;
        pcwrite    = w_jr || w_beq || w_j || w_jal;
        w_next     = w_lw ? S_MEMRD : w_sw ? S_MEMWR : (w_ralu || w_addi) ? S_WB : S_FETCH;
      end
      S_MEMRD, S_MEMWR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        alusrc     = 1'b1;
        alucontrol = 4'b0010;
        mem_we     = r_state == S_MEMWR;
        pcwrite    = r_state == S_MEMWR && mem_ready;
        w_next     = !mem_ready ? r_state : r_state == S_MEMWR ? S_FETCH : S_WB;
      end
      S_WB: begin
        regwrite   = w_ralu || w_lw || w_addi;
        pcwrite    = 1'b1;
        regdst     = w_ralu;
        memtoreg   = w_lw;
        alusrc     = w_lw || w_addi;
        alucontrol = w_ralu ? instr[3:0] : (w_lw || w_addi) ? 4'b0010 : 4'b0000;
        w_next     = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven per-cycle checks of the multicycle control FSM
module tb_multicycle_ctrl;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [31:0] instr = 32'h0;
  logic mem_req, mem_we, iord, irwrite, pcwrite, regwrite, memtoreg, alusrc, regdst;
  logic pcsrc, jump, jrsrc, jalsrc, halted;
  logic [3:0] alucontrol;
`ifdef CTRL_TRAP_EN
  logic illegal;
`endif
  logic [17:0] w_out;
  int checks = 0, failures = 0;

  localparam logic [17:0] MREQ = 18'h20000, MWE = 18'h10000, IORD = 18'h08000, IRW = 18'h04000;
  localparam logic [17:0] PCW = 18'h02000, RW = 18'h01000, M2R = 18'h00800, ASRC = 18'h00400;
  localparam logic [17:0] RDST = 18'h00200, PCS = 18'h00100, JMP = 18'h00080, JR = 18'h00040;
  localparam logic [17:0] JAL = 18'h00020, ALU2 = 18'h00004, ALU6 = 18'h0000C, HLT = 18'h00001;

  localparam logic [31:0] I_ADD = 32'h00000002, I_SUB = 32'h00000006, I_LW = 32'h8C000000;
  localparam logic [31:0] I_SW = 32'hAC000000, I_ADDI = 32'h20000000, I_BEQ = 32'h10000000;
  localparam logic [31:0] I_J = 32'h08000000, I_JAL = 32'h0C000000, I_JR = 32'h00000010;
  localparam logic [31:0] I_HALT = 32'hFC000000, I_UND = 32'hF8000000;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        rdy;
    logic [17:0] exp;
  } vec_t;
  vec_t vecs[$];

  multicycle_ctrl #(.N(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
    .regwrite(regwrite), .memtoreg(memtoreg), .alusrc(alusrc), .regdst(regdst), .pcsrc(pcsrc),
    .jump(jump), .jrsrc(jrsrc), .jalsrc(jalsrc), .alucontrol(alucontrol), .halted(halted)
`ifdef CTRL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  assign w_out = {mem_req, mem_we, iord, irwrite, pcwrite, regwrite, memtoreg, alusrc, regdst,
                  pcsrc, jump, jrsrc, jalsrc, alucontrol, halted};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: outputs got=%05h expected=%05h", name, got, exp);
    end
  endtask

  task automatic addv(input logic [31:0] i, input logic z, input logic r, input logic [17:0] e);
    vecs.push_back('{instr: i, zero: z, rdy: r, exp: e});
  endtask

  task automatic fd(input logic [31:0] i);
    addv(i, 1'b0, 1'b1, MREQ | IRW);
    addv(i, 1'b0, 1'b1, 18'h0);
  endtask

  task automatic step(input logic [31:0] i, input logic z, input logic r, input logic [17:0] e,
                      input string name);
    instr = i;
    zero = z;
    mem_ready = r;
    #1;
    check(name, w_out, e);
    @(negedge clk);
  endtask

  initial begin
    fd(I_ADD);
    addv(I_ADD, 1'b1, 1'b0, ALU2);
    addv(I_ADD, 1'b1, 1'b0, RW | RDST | PCW | ALU2);
    fd(I_SUB);
    addv(I_SUB, 1'b0, 1'b1, ALU6);
    addv(I_SUB, 1'b0, 1'b1, RW | RDST | PCW | ALU6);
    fd(I_LW);
    addv(I_LW, 1'b0, 1'b1, ASRC | ALU2);
    addv(I_LW, 1'b0, 1'b0, MREQ | IORD | ASRC | ALU2);
    addv(I_LW, 1'b0, 1'b0, MREQ | IORD | ASRC | ALU2);
    addv(I_LW, 1'b0, 1'b1, MREQ | IORD | ASRC | ALU2);
    addv(I_LW, 1'b0, 1'b1, RW | M2R | ASRC | PCW | ALU2);
    addv(I_SW, 1'b0, 1'b0, MREQ);
    fd(I_SW);
    addv(I_SW, 1'b0, 1'b1, ASRC | ALU2);
    addv(I_SW, 1'b0, 1'b0, MREQ | MWE | IORD | ASRC | ALU2);
    addv(I_SW, 1'b0, 1'b1, MREQ | MWE | IORD | ASRC | ALU2 | PCW);
    fd(I_ADDI);
    addv(I_ADDI, 1'b0, 1'b1, ASRC | ALU2);
    addv(I_ADDI, 1'b0, 1'b1, RW | ASRC | ALU2 | PCW);
    fd(I_BEQ);
    addv(I_BEQ, 1'b1, 1'b1, ALU6 | PCS | PCW);
    fd(I_BEQ);
    addv(I_BEQ, 1'b0, 1'b1, ALU6 | PCW);
    fd(I_J);
    addv(I_J, 1'b0, 1'b1, JMP | PCW);
    fd(I_JAL);
    addv(I_JAL, 1'b0, 1'b0, JMP | JAL | RW | PCW);
    fd(I_JR);
    addv(I_JR, 1'b0, 1'b1, JR | PCW);
    addv(I_ADD, 1'b0, 1'b0, MREQ);

    #1;
    check("reset_outputs", w_out, 18'h0);
    @(negedge clk);
    check("reset_held", w_out, 18'h0);
    reset = 1'b0;
    foreach (vecs[k]) step(vecs[k].instr, vecs[k].zero, vecs[k].rdy, vecs[k].exp, $sformatf("vec%0d", k));

    step(I_SW, 1'b0, 1'b1, MREQ | IRW, "rst_sw_fetch");
    step(I_SW, 1'b0, 1'b0, 18'h0, "rst_sw_decode");
    step(I_SW, 1'b0, 1'b0, ASRC | ALU2, "rst_sw_exec");
    step(I_SW, 1'b0, 1'b0, MREQ | MWE | IORD | ASRC | ALU2, "rst_sw_memwr_wait");
    #2;
    reset = 1'b1;
    #1;
    check("rst_midaccess_req_we", {16'h0, mem_req, mem_we}, 18'h0);
    check("rst_midaccess_all", w_out, 18'h0);
    @(negedge clk);
    reset = 1'b0;
    step(I_ADD, 1'b0, 1'b1, MREQ | IRW, "rst_restart_fetch");
    step(I_ADD, 1'b0, 1'b1, 18'h0, "rst_restart_decode");

    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    step(I_UND, 1'b0, 1'b1, MREQ | IRW, "und_fetch");
    step(I_UND, 1'b0, 1'b1, 18'h0, "und_decode");
`ifdef CTRL_TRAP_EN
    step(I_UND, 1'b0, 1'b1, HLT, "und_trap_halt");
    check("und_illegal", {17'h0, illegal}, 18'h1);
    step(I_UND, 1'b0, 1'b1, HLT, "und_trap_halt_hold");
    check("und_illegal_hold", {17'h0, illegal}, 18'h1);
    reset = 1'b1;
    #1;
    check("und_illegal_reset", {17'h0, illegal}, 18'h0);
    @(negedge clk);
    reset = 1'b0;
`else
    step(I_UND, 1'b0, 1'b1, PCW, "und_nop_wb");
`endif
    step(I_HALT, 1'b0, 1'b1, MREQ | IRW, "halt_fetch");
    step(I_HALT, 1'b0, 1'b1, 18'h0, "halt_decode");
    step(I_HALT, 1'b0, 1'b1, HLT, "halt_state");
    step(I_ADD, 1'b1, 1'b0, HLT, "halt_absorb1");
    step(I_LW, 1'b0, 1'b1, HLT, "halt_absorb2");
`ifdef CTRL_TRAP_EN
    check("halt_not_illegal", {17'h0, illegal}, 18'h0);
`endif
    reset = 1'b1;
    #1;
    check("halt_reset", w_out, 18'h0);
    @(negedge clk);
    reset = 1'b0;
    step(I_ADD, 1'b0, 1'b0, MREQ, "halt_exit_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
